filter_feeder: RTL and testbench
================================

Name: filter_feeder

Overview:
- Paced sample source for the `filters` datapath. It is the producing end of the `x`/`x_is_valid` interface.
- Upstream logic pushes WIDTH-bit samples into an internal FIFO through a valid/ready handshake.
- A programmable rate divider pops one sample every (div+1) cycles and drives it onto `x`, with a one-cycle `x_is_valid` strobe.
- A prime state holds off emission until the FIFO holds enough samples. A sticky flag records underruns.

Parameters:
- WIDTH, 4, sample width; matches the filter `x` input.
- DEPTH, 8, FIFO depth in samples; power of 2, minimum 2.
- DIV_W, 8, width of the rate divider.
- PRIME, 2, FIFO level required before emission starts; 1..DEPTH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- en  in  1  run enable; 0 forces the IDLE state.
- div  in  DIV_W  emission period minus 1; 0 means every cycle.
- in_data  in  WIDTH  upstream sample.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  FIFO can accept a sample.
- x  out  WIDTH  sample to the filter.
- x_is_valid  out  1  one-cycle strobe; x is valid this cycle.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- underrun  out  1  sticky: a tick occurred while RUN and the FIFO was empty.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset values: x=0, x_is_valid=0, underrun=0, level=0, state=IDLE, divider count=0, FIFO pointers=0.
- While rst==0: in_ready=0. Reset mid-stream discards all FIFO contents.
- in_ready = rst && (level < DEPTH). It is combinational from registered level; there is no full-bypass.
  - When full, in_ready=0, even if a pop occurs in the same cycle.
- Push occurs when in_valid && in_ready. The sample is visible to a pop from the next cycle; there is no empty-bypass.
- Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Level range is 0..DEPTH.
- FSM:
  - IDLE: count held at 0, no ticks. Go to PRIME when en=1.
  - PRIME: count held at 0. Go to RUN when level >= PRIME.
  - RUN: count increments each cycle. Tick when count >= div, then count <= 0.
  - Any state goes to IDLE on the cycle after en=0 is sampled. FIFO contents are retained in IDLE.
  - RUN does not return to PRIME on empty; it underruns instead.
- Tick in RUN with FIFO not empty:
  - Pop; registered output: x <= head, x_is_valid <= 1 for exactly one cycle.
  - Latency from tick cycle to x_is_valid is 1 clk.
- Tick in RUN with FIFO empty:
  - underrun <= 1; x_is_valid stays 0; x unchanged.
  - If a push occurs in the same cycle, that sample is not used; it is emitted on a later tick.
- x holds its last emitted value between strobes. x_is_valid=0 whenever there is no tick.
- div is sampled every cycle. Lowering div below the current count produces a tick on the next cycle (>= compare).
- div=0 gives one sample per cycle, i.e. x_is_valid continuous while the FIFO has data.
- clr_underrun clears underrun. If set and clear coincide, set wins.

Decomposition:
- Shared package `filter_pkg` holds:
  - SAMPLE_W=4, shared with `filters`;
  - the state enum IDLE/PRIME/RUN (2-bit encoding);
  - the default DEPTH and PRIME values.
- One sub-module: `sync_fifo`, parameterised WIDTH/DEPTH, with push/pop/level and no bypass.
  - It is reusable for a future capture block on the filter output.
- The FSM, divider and output register live in `filter_feeder`.

Test Plan:
- Reset: hold rst=0 for 3 cycles while in_valid=1 -> in_ready=0, x=0, x_is_valid=0, level=0, underrun=0; no push accepted.
- Prime and pacing: push 3, 5, 9 back-to-back, en=1, div=2, PRIME=2 -> RUN entered once level=2; x_is_valid strobes exactly 3 cycles apart with x=3, 5, 9; level ends at 0.
- Underrun: continue from the previous case with no more pushes -> on the next tick underrun=1 and x stays 9. Assert clr_underrun on a non-tick cycle -> underrun=0. Assert clr_underrun on a tick cycle that finds the FIFO empty -> underrun stays 1 (set wins).
- Full boundary: en=0, push 9 samples with DEPTH=8 -> 8 accepted, in_ready=0 at level=8, and the 9th is held by upstream. Set en=1, div=0 -> 8 consecutive strobes in FIFO order.
- Wrap-around: DEPTH=8, div=0, continuous push of values 0..15 -> x sequence is 0..15 in order with no loss or duplication, and level never exceeds 8.
- Reset and disable mid-stream:
  - Assert rst=0 while level=4 and RUN -> next cycle level=0, state IDLE, no further strobes.
  - Separately, drop en while RUN -> strobes stop within 1 cycle; FIFO level is retained.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the filter datapath and its sample feeder.
package filter_pkg;

    localparam int SAMPLE_W  = 4;
    localparam int DEPTH_DEF = 8;
    localparam int PRIME_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/filter_feeder_if.sv
// Upstream push handshake plus the paced x/x_is_valid stream to the filter.
interface filter_feeder_if #(
    parameter int WIDTH = filter_pkg::SAMPLE_W
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             x_is_valid;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x,
        output x_is_valid
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x,
        input  x_is_valid
    );
endinterface

// File: rtl/filter_feeder_sync_fifo.sv
// Single-clock FIFO with registered level and no full/empty bypass paths.
module sync_fifo
    import filter_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];
    assign level_o = level_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/filter_feeder.sv
// Paced sample source: buffers upstream samples and emits one every div+1 cycles.
//   state    | meaning
//   ST_IDLE  | disabled, divider held at 0, FIFO contents retained
//   ST_PRIME | enabled, waiting for FIFO level >= PRIME
//   ST_RUN   | divider counting; each tick pops a sample or flags underrun
module filter_feeder
    import filter_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DIV_W = 8,
    parameter int PRIME = PRIME_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_W-1:0]       div,
    input  logic                   clr_underrun,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    filter_feeder_if.master        bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    feeder_state_e    state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             xv_q, xv_d;
    logic             under_q, under_d;

    logic             tick;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    assign bus.in_ready   = rst && !fifo_full;
    assign push           = bus.in_valid && bus.in_ready;
    assign bus.x          = x_q;
    assign bus.x_is_valid = xv_q;
    assign underrun       = under_q;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.in_data),
        .rdata_o (fifo_head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A tick is decided by the current state alone; en=0 only redirects the next state.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        tick    = 1'b0;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_PRIME;
            ST_PRIME: if (level >= LVL_W'(PRIME)) state_d = ST_RUN;
            ST_RUN: begin
                if (count_q >= div) tick = 1'b1;
                else                count_d = count_q + DIV_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d = ST_IDLE;
            count_d = '0;
        end

        pop     = tick && !fifo_empty;
        x_d     = pop ? fifo_head : x_q;
        xv_d    = pop;
        under_d = (tick && fifo_empty) || (under_q && !clr_underrun);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            x_q     <= '0;
            xv_q    <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            under_q <= under_d;
        end
    end
endmodule

// File: tb/tb_filter_feeder.sv
// Directed and random stimulus for filter_feeder against a queue-based reference model.
module tb_filter_feeder;
    import filter_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int PRIME = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr_underrun = 1'b0;
    logic [7:0] div = '0;
    logic [3:0] level;
    logic       underrun;

    filter_feeder_if #(.WIDTH(W)) bus ();

    filter_feeder #(
        .WIDTH (W),
        .DEPTH (DEPTH),
        .DIV_W (8),
        .PRIME (PRIME)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div          (div),
        .clr_underrun (clr_underrun),
        .level        (level),
        .underrun     (underrun),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: FIFO as a queue, phase 0=idle 1=priming 2=running.
    int m_q[$];
    int m_phase = 0;
    int m_count = 0;
    int m_x     = 0;
    int m_xv    = 0;
    int m_under = 0;

    bit         chk_on = 1'b0;
    int         cyc = 0;
    int         max_level = 0;
    int         s_val[$];
    int         s_cyc[$];
    logic       o_ready, o_xv, o_under;
    logic [3:0] o_x;
    logic [3:0] o_level;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tick_pending();
        return (m_phase == 2) && (m_count >= int'(div));
    endfunction

    task automatic model_step();
        int sz;
        bit push_ok;
        bit tick;
        if (!rst) begin
            m_q.delete();
            m_phase = 0;
            m_count = 0;
            m_x     = 0;
            m_xv    = 0;
            m_under = 0;
            return;
        end
        sz      = m_q.size();
        push_ok = bus.in_valid && (sz < DEPTH);
        tick    = tick_pending();
        m_xv    = 0;
        if (tick && sz > 0) begin
            m_x  = m_q.pop_front();
            m_xv = 1;
        end
        if (tick && sz == 0)   m_under = 1;
        else if (clr_underrun) m_under = 0;
        if (push_ok) m_q.push_back(int'(bus.in_data));
        if (!en) begin
            m_phase = 0;
            m_count = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_count = 0;
        end else if (m_phase == 1) begin
            if (sz >= PRIME) m_phase = 2;
            m_count = 0;
        end else begin
            m_count = tick ? 0 : m_count + 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        o_ready = bus.in_ready;
        o_xv    = bus.x_is_valid;
        o_x     = bus.x;
        o_level = level;
        o_under = underrun;
        if (chk_on) begin
            chk("in_ready",   o_ready, (rst && m_q.size() < DEPTH) ? 1 : 0);
            chk("x_is_valid", o_xv,    m_xv);
            chk("x",          o_x,     m_x);
            chk("level",      o_level, m_q.size());
            chk("underrun",   o_under, m_under);
            if (o_xv === 1'b1) begin
                s_val.push_back(int'(o_x));
                s_cyc.push_back(cyc);
            end
            if (int'(o_level) > max_level) max_level = int'(o_level);
        end
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int lvl;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h7;

        // Reset held with upstream valid asserted
        rst = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        step();
        step();
        chk("rst_ready", o_ready, 0);
        chk("rst_level", o_level, 0);
        chk("rst_xv", o_xv, 0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        step();
        chk("rst_no_push", o_level, 0);

        // Prime and pacing: 3,5,9 with div=2
        s_val.delete(); s_cyc.delete();
        en = 1'b1; div = 8'd2;
        bus.in_valid = 1'b1;
        bus.in_data = 4'd3; step();
        bus.in_data = 4'd5; step();
        bus.in_data = 4'd9; step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && s_val.size() < 3; i++) step();
        chk("pace_count", s_val.size(), 3);
        if (s_val.size() == 3) begin
            chk("pace_x0", s_val[0], 3);
            chk("pace_x1", s_val[1], 5);
            chk("pace_x2", s_val[2], 9);
            chk("pace_gap0", s_cyc[1] - s_cyc[0], 3);
            chk("pace_gap1", s_cyc[2] - s_cyc[1], 3);
        end
        chk("pace_level", o_level, 0);

        // Underrun, clear on a non-tick cycle, then set-wins on a tick cycle
        for (int i = 0; i < 20 && o_under !== 1'b1; i++) step();
        chk("under_set", o_under, 1);
        chk("under_x_hold", o_x, 9);
        for (int i = 0; i < 10 && tick_pending(); i++) step();
        clr_underrun = 1'b1; step();
        clr_underrun = 1'b0; step();
        chk("under_clr", o_under, 0);
        for (int i = 0; i < 10 && !tick_pending(); i++) step();
        clr_underrun = 1'b1; step();
        clr_underrun = 1'b0; step();
        chk("under_set_wins", o_under, 1);

        // Full boundary: 9 offered while idle, 8 accepted
        en = 1'b0;
        clr_underrun = 1'b1; step(); step();
        clr_underrun = 1'b0;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(acc + 1);
            step();
            if (o_ready === 1'b1) acc++;
        end
        chk("full_accepted", acc, 8);
        chk("full_level", o_level, 8);
        chk("full_ready", o_ready, 0);
        bus.in_valid = 1'b0;
        s_val.delete(); s_cyc.delete();
        en = 1'b1; div = 8'd0;
        for (int i = 0; i < 30 && s_val.size() < 8; i++) step();
        chk("drain_count", s_val.size(), 8);
        if (s_val.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("drain_x", s_val[i], i + 1);
                if (i > 0) chk("drain_gap", s_cyc[i] - s_cyc[i-1], 1);
            end
        end

        // Wrap-around: continuous push 0..15 at div=0
        s_val.delete(); s_cyc.delete();
        max_level = 0;
        acc = 0;
        for (int i = 0; i < 80 && (acc < 16 || s_val.size() < 16); i++) begin
            bus.in_valid = (acc < 16);
            bus.in_data  = 4'(acc);
            step();
            if (bus.in_valid && o_ready === 1'b1) acc++;
        end
        bus.in_valid = 1'b0;
        chk("wrap_count", s_val.size(), 16);
        if (s_val.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("wrap_x", s_val[i], i);
        end
        chk("wrap_max_level", (max_level <= DEPTH) ? 1 : 0, 1);

        // Reset mid-stream with level=4 while running
        div = 8'd200;
        acc = 0;
        for (int i = 0; i < 10 && acc < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(acc + 10);
            step();
            if (o_ready === 1'b1) acc++;
        end
        bus.in_valid = 1'b0;
        step();
        chk("mid_level4", o_level, 4);
        rst = 1'b0; step();
        rst = 1'b1; step();
        chk("mid_rst_level", o_level, 0);
        div = 8'd0;
        s_val.delete(); s_cyc.delete();
        for (int i = 0; i < 10; i++) step();
        chk("mid_rst_no_strobe", s_val.size(), 0);

        // Disable while running: strobes stop, level retained
        div = 8'd3;
        acc = 0;
        for (int i = 0; i < 40 && (acc < 6 || s_val.size() < 1); i++) begin
            bus.in_valid = (acc < 6);
            bus.in_data  = 4'(acc + 2);
            step();
            if (bus.in_valid && o_ready === 1'b1) acc++;
        end
        bus.in_valid = 1'b0;
        chk("dis_first_strobe", (s_val.size() >= 1) ? 1 : 0, 1);
        en = 1'b0;
        step();
        step();
        lvl = int'(o_level);
        s_val.delete(); s_cyc.delete();
        for (int i = 0; i < 5; i++) step();
        chk("dis_no_strobe", s_val.size(), 0);
        chk("dis_level_kept", o_level, lvl);
        chk("dis_level_nonzero", (lvl > 0) ? 1 : 0, 1);

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) div = 8'($urandom_range(0, 3));
            rst          = ($urandom_range(0, 99) != 0);
            en           = ($urandom_range(0, 19) != 0);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_data  = 4'($urandom_range(0, 15));
            clr_underrun = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
